btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_cond_pkg.sv | 15 +
 rtl/btn_debounce_ch.sv | 132 +++++++++++++
 rtl/btn_conditioner.sv | 36 +++
 tb/tb_btn_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM state
// encoding and default timing constants.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned LONG_CYCLES_DEF     = 50000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with a saturating
// stability counter, and (with BTN_LONG_PRESS_EN) a long-press hold counter.
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("btn_debounce_ch: need 1 <= DEBOUNCE_CYCLES < LONG_CYCLES");
    end

    logic [1:0]    sync;
    logic          synced;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    assign synced = sync[1];

    // Bring the asynchronous raw button into the clock domain; resets to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], raw_n};
        end
    end

    // Debounce FSM: an edge is accepted only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            level_n       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                ST_RELEASED: begin
                    if (!synced) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (synced) begin
                        state <= ST_RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ST_HELD;
                        level_n     <= 1'b0;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (synced) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!synced) begin
                        state <= ST_HELD;
                    end else if (cnt == CNT_LAST) begin
                        state         <= ST_RELEASED;
                        level_n       <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_RELEASED;
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_CYCLES - DEBOUNCE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - DEBOUNCE_CYCLES - 1);

    logic [HW-1:0] hold;
    logic          fired;
    logic          long_q;
    logic          enter_held;

    // Only a fresh press re-arms the hold counter; bounces back into HELD do not.
    assign enter_held = (state == ST_PRESS_WAIT) && !synced && (cnt == CNT_LAST);
    assign long_pulse = long_q;

    // Hold-duration counter: saturates at its target and fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold   <= '0;
            fired  <= 1'b0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (enter_held) begin
                hold  <= '0;
                fired <= 1'b0;
            end else if (state == ST_HELD || state == ST_RELEASE_WAIT) begin
                if (hold == HOLD_LAST) begin
                    if (!fired) begin
                        long_q <= 1'b1;
                        fired  <= 1'b1;
                    end
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: N_BTN independent debounce channels producing a
// clean active-low level plus press/release pulses.
// Optional feature macro: BTN_LONG_PRESS_EN (adds btn_long long-press pulses).
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] btn_level_n,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    // One fully independent conditioner per button.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .raw_n        (btn_raw_n[i]),
            .level_n      (btn_level_n[i]),
            .press_pulse  (btn_press[i]),
            .release_pulse(btn_release[i]),
            .long_pulse   (btn_long[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Directed scenarios check fixed cycle numbers; a random scenario compares
// every cycle against a behavioural model of the debounce rules.
module tb_btn_conditioner;

    localparam int N  = 3;
    localparam int DC = 4;
    localparam int LC = 20;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] raw_n;
    logic [N-1:0] level_n, press, rel, lng;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DC),
        .LONG_CYCLES    (LC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_n  (raw_n),
        .btn_level_n(level_n),
        .btn_press  (press),
        .btn_release(rel),
        .btn_long   (lng)
    );

    // Behavioural model: after a 2-sample synchronizer delay, the debounced
    // level flips once DC+1 consecutive samples disagree with it; long press
    // fires once when the level has been low for LC-DC edges.
    logic [N-1:0] m_s1, m_s2, m_level_n, m_press, m_release, m_long;
    int run [N];
    int age [N];
    bit fired [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_level_n = '1;
            m_press = '0; m_release = '0; m_long = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = 0; age[i] = 0; fired[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_press[i] = 1'b0; m_release[i] = 1'b0; m_long[i] = 1'b0;
                if (!m_level_n[i]) begin
                    age[i]++;
                    if (LONG_EN && age[i] == LC - DC && !fired[i]) begin
                        m_long[i] = 1'b1;
                        fired[i]  = 1;
                    end
                end
                if (m_s2[i] != m_level_n[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == DC + 1) begin
                    m_level_n[i] = m_s2[i];
                    run[i] = 0;
                    if (!m_s2[i]) begin
                        m_press[i] = 1'b1; age[i] = 0; fired[i] = 0;
                    end else begin
                        m_release[i] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_n;
        end
    end

    // Reset sequence (no checking); returns on a negedge, the next posedge is edge 0.
    task automatic do_reset(input logic [N-1:0] rv);
        @(negedge clk);
        rst_n = 1'b0;
        raw_n = rv;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4*N-1:0] exp_v;
        @(negedge clk);
        rst_n = 1'b0;
        raw_n = '0;
        @(negedge clk);
        n_cmp++;
        if ({level_n, press, rel, lng} !== {3'b111, 3'b000, 3'b000, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_hold got=%b exp=%b", {level_n, press, rel, lng}, 12'b111000000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = {(c >= 6) ? 3'b000 : 3'b111, (c == 6) ? 3'b111 : 3'b000, 3'b000, 3'b000};
            n_cmp++;
            if ({level_n, press, rel, lng} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", c, {level_n, press, rel, lng}, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4*N-1:0] exp_v;
        do_reset('1);
        raw_n = 3'b110;
        for (int c = 0; c <= 44; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = {(c >= 6 && c < 36) ? 3'b110 : 3'b111,
                     (c == 6)  ? 3'b001 : 3'b000,
                     (c == 36) ? 3'b001 : 3'b000,
                     (LONG_EN && c == 22) ? 3'b001 : 3'b000};
            n_cmp++;
            if ({level_n, press, rel, lng} !== exp_v) begin
                n_fail++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", c, {level_n, press, rel, lng}, exp_v);
            end
            if (c == 29) raw_n = 3'b111;
        end
    endtask

    task automatic test_glitch();
        logic [4*N-1:0] exp_v;
        do_reset('1);
        raw_n = 3'b011;
        for (int c = 0; c <= 50; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = {(c >= 16 && c < 47) ? 3'b011 : 3'b111,
                     (c == 16) ? 3'b100 : 3'b000,
                     (c == 47) ? 3'b100 : 3'b000,
                     (LONG_EN && c == 32) ? 3'b100 : 3'b000};
            n_cmp++;
            if ({level_n, press, rel, lng} !== exp_v) begin
                n_fail++;
                $display("FAIL glitch cyc=%0d got=%b exp=%b", c, {level_n, press, rel, lng}, exp_v);
            end
            if (c == 2 || c == 24 || c == 40) raw_n = 3'b111;
            if (c == 9 || c == 25) raw_n = 3'b011;
        end
    endtask

    task automatic test_long_press();
        logic [4*N-1:0] exp_v;
        do_reset('1);
        raw_n = 3'b101;
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = {(c >= 6 && c < 46) ? 3'b101 : 3'b111,
                     (c == 6)  ? 3'b010 : 3'b000,
                     (c == 46) ? 3'b010 : 3'b000,
                     (LONG_EN && c == 22) ? 3'b010 : 3'b000};
            n_cmp++;
            if ({level_n, press, rel, lng} !== exp_v) begin
                n_fail++;
                $display("FAIL long_press cyc=%0d got=%b exp=%b", c, {level_n, press, rel, lng}, exp_v);
            end
            if (c == 39) raw_n = 3'b111;
        end
    endtask

    task automatic test_reset_mid();
        do_reset('1);
        raw_n = 3'b000;
        for (int c = 0; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({level_n, press, rel, lng} !== {3'b111, 9'b0}) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", c, {level_n, press, rel, lng}, {3'b111, 9'b0});
            end
            n_cmp++;
            if ({level_n, press, rel, lng} !== {m_level_n, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL reset_mid_model cyc=%0d got=%b exp=%b", c, {level_n, press, rel, lng},
                         {m_level_n, m_press, m_release, m_long});
            end
            if (c == 2) begin
                rst_n = 1'b0;
                raw_n = 3'b111;
            end
            if (c == 4) rst_n = 1'b1;
        end
    endtask

    task automatic test_random();
        int remain [N];
        int seen_press = 0;
        do_reset('1);
        for (int i = 0; i < N; i++) remain[i] = $urandom_range(1, 30);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({level_n, press, rel, lng} !== {m_level_n, m_press, m_release, m_long}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, {level_n, press, rel, lng},
                         {m_level_n, m_press, m_release, m_long});
            end
            if (press != '0) seen_press++;
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < N; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    raw_n[i]  = ~raw_n[i];
                    remain[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
                end
            end
        end
        rst_n = 1'b1;
        n_cmp++;
        if (seen_press == 0) begin
            n_fail++;
            $display("FAIL random_activity got=%0d press cycles exp=nonzero", seen_press);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        raw_n = '1;
        #1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_press();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
